// File: rtl/sprite_ram_pkg.sv
// Shared constants and types for the sprite attribute RAM and its arbiter.
// Attribute layout: X at SPRITE_BASE+OFF_X, Y at +OFF_Y, walk mode at +OFF_MODE.
package sprite_ram_pkg;

  localparam int N_REQ_DEFAULT = 4;

  localparam logic [15:0] SPRITE_BASE = 16'h1000;
  localparam logic [15:0] OFF_X       = 16'd0;
  localparam logic [15:0] OFF_Y       = 16'd1;
  localparam logic [15:0] OFF_MODE    = 16'd2;

  typedef enum logic [1:0] {
    STANDING   = 2'd0,
    WALK_START = 2'd1,
    WALK_MID   = 2'd2,
    WALK_END   = 2'd3
  } walk_mode_e;

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Index width for an n-entry vector, never below one bit.
  function automatic int idx_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sprite_ram_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request strictly after ptr,
// wrapping around, returned both one-hot and as an index.
module rr_pick
  import sprite_ram_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int IW    = idx_bits(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  int          cand_i;
  logic [IW-1:0] cand;

  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    cand_i = 0;
    cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      // ptr <= N_REQ-1 and k <= N_REQ, so one subtraction is enough to wrap.
      cand_i = int'(ptr) + k;
      if (cand_i >= N_REQ) cand_i = cand_i - N_REQ;
      cand = cand_i[IW-1:0];
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/sprite_ram_arbiter.sv
// Round-robin arbiter with per-requester lock in front of the single-port,
// write-first sprite attribute RAM; reads return two cycles after accept.
//
//   state  | meaning
//   FREE   | no owner, all requesters arbitrated round-robin
//   LOCKED | owner_q alone is eligible; idle counter guards against a stuck lock
module sprite_ram_arbiter
  import sprite_ram_pkg::*;
#(
  parameter int N_REQ        = N_REQ_DEFAULT,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ-1:0]            req_lock,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic [N_REQ-1:0]            lock_abort,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  output logic                        mem_we,
  input  logic [DATA_WIDTH-1:0]       mem_rdata
);

  localparam int IW = idx_bits(N_REQ);
  localparam int CW = idx_bits(LOCK_TIMEOUT + 1);

  lock_state_e     state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [IW-1:0]   rr_ptr_q;
  logic            fire;

  logic [N_REQ-1:0] owner_mask;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    win;
  logic             accept;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_we;
  logic                  sel_lock;

  logic            s1_vld, s2_vld;
  logic [IW-1:0]   s1_id, s2_id;

  assign owner_mask = N_REQ'(1) << owner_q;

  always_comb begin
    elig = req_valid;
    if (reset) elig = '0;
    else if (state_q == LOCKED) elig = req_valid & owner_mask;
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req   (elig),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (win),
    .any   (accept)
  );

  assign req_ready = grant;

  // grant is one-hot, so an OR-style mux of the winner's fields suffices.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_we    = req_we[i];
        sel_lock  = req_lock[i];
      end
    end
  end

  // Lock FSM next state; an accept always beats a timeout in the same cycle.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    idle_cnt_d = idle_cnt_q;
    fire       = 1'b0;
    if (accept) begin
      idle_cnt_d = '0;
      if (sel_lock) begin
        state_d = LOCKED;
        owner_d = win;
      end else begin
        state_d = FREE;
      end
    end else if (state_q == LOCKED) begin
      if (idle_cnt_q == CW'(LOCK_TIMEOUT)) begin
        fire       = 1'b1;
        state_d    = FREE;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + CW'(1);
      end
    end
  end

  assign lock_abort = (fire && !reset) ? owner_mask : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FREE;
      owner_q    <= '0;
      idle_cnt_q <= '0;
      rr_ptr_q   <= IW'(N_REQ - 1);
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      s1_vld     <= 1'b0;
      s1_id      <= '0;
      s2_vld     <= 1'b0;
      s2_id      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      idle_cnt_q <= idle_cnt_d;
      mem_we     <= accept & sel_we;
      if (accept) begin
        rr_ptr_q  <= win;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      s1_vld <= accept & ~sel_we;
      s1_id  <= win;
      s2_vld <= s1_vld;
      s2_id  <= s1_id;
    end
  end

  // The RAM registers its output, so the data is already aligned with s2.
  assign rsp_valid = s2_vld ? (N_REQ'(1) << s2_id) : '0;
  assign rsp_data  = s2_vld ? mem_rdata : '0;

endmodule
